// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: byte-serial add/subtract through a single shared 8-bit adder
module adder_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sub,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES:0]   s,
    output logic                ovf
);
    localparam int W  = 8 * NBYTES;
    localparam int IW = $clog2(NBYTES);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
    logic [IW-1:0] idx;
    logic          carry;
    logic [7:0]    ab;
    logic [7:0]    bb;
    logic [8:0]    sum;
    logic          last;

    assign ab   = opa[8*idx +: 8];
    assign bb   = opb[8*idx +: 8];
    assign sum  = {1'b0, ab} + {1'b0, bb} + {8'd0, carry};
    assign last = idx == IW'(NBYTES - 1);
    assign busy = state == RUN;
    assign done = state == DONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            opa   <= '0;
            opb   <= '0;
            idx   <= '0;
            carry <= 1'b0;
            s     <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    opa   <= a;
                    opb   <= sub ? ~b : b;
                    carry <= sub;
                    idx   <= '0;
                    s     <= '0;
                    ovf   <= 1'b0;
                    state <= RUN;
                end
                RUN: begin
                    s[8*idx +: 8] <= sum[7:0];
                    carry         <= sum[8];
                    idx           <= last ? '0 : idx + 1'b1;
                    // Final byte: carry-out becomes s[W], sign bits give overflow
                    if (last) begin
                        s[W]  <= sum[8];
                        ovf   <= (opa[W-1] == opb[W-1]) && (sum[7] != opa[W-1]);
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
